// File: rtl/keypad_scan_rx_pkg.sv
// Shared definitions for the keypad scan receiver: FSM state codes,
// idle row pattern and the row priority encoder.
package keypad_scan_rx_pkg;

    // FSM state codes kept numerically identical to the legacy encodings
    localparam logic [1:0] ST_SCAN        = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

    // Rows are pulled up, so no key on the driven column reads all ones
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    // Index of the lowest-numbered active-low row; lowest index has priority
    function automatic logic [1:0] row_encode(input logic [3:0] rows);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!rows[3 - i]) idx = 2'(3 - i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_rx_scan_tick_gen.sv
// Scan timebase: free-running SCAN_DIV-bit counter that emits a one-cycle
// tick whenever the counter wraps back to zero.
module scan_tick_gen
    import keypad_scan_rx_pkg::*;
#(
    parameter int SCAN_DIV = 13
) (
    input  logic clk_in,
    input  logic reset,
    output logic tick
);

    logic [SCAN_DIV-1:0] r_cnt;
    logic                r_tick;

    // Count continuously; tick is high during the cycle the counter reads zero
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + SCAN_DIV'(1);
            r_tick <= (r_cnt == '1);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/keypad_scan_rx.sv
// 4x4 scanned keypad receiver: drives one active-low column at a time,
// synchronises the pulled-up rows, debounces press and release on scan
// ticks and reports each accepted key with a one-cycle valid strobe.
module keypad_scan_rx
    import keypad_scan_rx_pkg::*;
#(
    parameter int SCAN_DIV     = 13,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             CW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_CNT);

    logic          w_tick;
    logic [3:0]    r_rs1;
    logic [3:0]    r_rs2;
    logic [1:0]    r_state;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_pat;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_held;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .tick   (w_tick)
    );

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_rs1 <= ROWS_IDLE;
            r_rs2 <= ROWS_IDLE;
        end else begin
            r_rs1 <= key_row;
            r_rs2 <= r_rs1;
        end
    end

    // Saturating debounce increment so the count can never wrap
    assign w_cnt_inc = (r_cnt == CNT_DONE) ? r_cnt : r_cnt + CW'(1);

    // Scan/debounce FSM; the column index doubles as the latched column
    // because it is frozen for as long as the FSM is outside SCAN
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_col_idx   <= '0;
            r_pat       <= ROWS_IDLE;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (r_rs2 == ROWS_IDLE) begin
                            r_col_idx <= r_col_idx + 2'd1;
                        end else begin
                            r_pat   <= r_rs2;
                            r_cnt   <= CW'(1);
                            r_state <= ST_DEB_PRESS;
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (r_rs2 == r_pat) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_DONE) begin
                                r_key_code  <= {row_encode(r_pat), r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_state     <= ST_PRESSED;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_SCAN;
                        end
                    end
                    ST_PRESSED: begin
                        if (r_rs2 == ROWS_IDLE) begin
                            r_cnt   <= CW'(1);
                            r_state <= ST_DEB_RELEASE;
                        end
                    end
                    ST_DEB_RELEASE: begin
                        if (r_rs2 == ROWS_IDLE) begin
                            if (w_cnt_inc == CNT_DONE) begin
                                r_key_held <= 1'b0;
                                r_cnt      <= '0;
                                r_state    <= ST_SCAN;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_state <= ST_PRESSED;
                        end
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end
        end
    end

    assign key_col   = ~(4'b0001 << r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
